// File: rtl/vdp_pkg.sv
// rtl/vdp_pkg.sv - shared types and constants for the VDP command sequencer
package vdp_pkg;

    localparam int VDP_ADDR_W = 14;
    localparam int VDP_CRAM_W = 5;

    // Access code carried in the top two bits of the second control byte
    typedef enum logic [1:0] {
        VRD   = 2'd0,
        VWR   = 2'd1,
        REGW  = 2'd2,
        CRAMW = 2'd3
    } vdp_code_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        VREQ = 2'd1,
        VCAP = 2'd2
    } cmd_state_t;

endpackage

// File: rtl/vdp_cmd_ctrl.sv
// rtl/vdp_cmd_ctrl.sv - VDP control/data port command sequencer
//
// Decodes the two-byte control-port protocol and data-port accesses, owns the
// auto-incrementing access address and the read-ahead buffer, and issues
// register-file, CRAM and VRAM (req/gnt) operations.
//
// Ports:
//   clk, rst                         clock, async active-high reset
//   wr_stb, rd_stb, mode, data_in    CPU port strobes (mode 1 = control port)
//   data_out, status_in, status_clr  CPU read data, status source, status clear
//   rf_addr, rf_data, rf_en          register-file write
//   cram_addr, cram_wdata, cram_we   CRAM write
//   vram_addr, vram_wdata, vram_we,
//   vram_req, vram_gnt, vram_rdata   VRAM access handshake
//   busy, drop                       not-IDLE flag, ignored-strobe pulse
module vdp_cmd_ctrl
    import vdp_pkg::*;
#(
    parameter int ADDR_W = VDP_ADDR_W,
    parameter int CRAM_W = VDP_CRAM_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_stb,
    input  logic              rd_stb,
    input  logic              mode,
    input  logic [7:0]        data_in,
    output logic [7:0]        data_out,
    input  logic [7:0]        status_in,
    output logic              status_clr,
    output logic [3:0]        rf_addr,
    output logic [7:0]        rf_data,
    output logic              rf_en,
    output logic [CRAM_W-1:0] cram_addr,
    output logic [5:0]        cram_wdata,
    output logic              cram_we,
    output logic [ADDR_W-1:0] vram_addr,
    output logic [7:0]        vram_wdata,
    output logic              vram_we,
    output logic              vram_req,
    input  logic              vram_gnt,
    input  logic [7:0]        vram_rdata,
    output logic              busy,
    output logic              drop
);

    cmd_state_t        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d, addr_cur;
    vdp_code_t         code_q, code_d;
    logic [7:0]        first_byte_q, first_byte_d;
    logic              latch_q, latch_d;
    logic [7:0]        read_buf_q, read_buf_d;
    logic              rf_en_q, rf_en_d;
    logic [3:0]        rf_addr_q, rf_addr_d;
    logic [7:0]        rf_data_q, rf_data_d;
    logic              cram_we_q, cram_we_d;
    logic [CRAM_W-1:0] cram_addr_q, cram_addr_d;
    logic [5:0]        cram_wdata_q, cram_wdata_d;
    logic              status_clr_q, status_clr_d;
    logic              vram_we_q, vram_we_d;
    logic [7:0]        vram_wdata_q, vram_wdata_d;
    logic              drop_q, drop_d;
    logic              wr_go, rd_go;

    // Strobes only act in IDLE; a simultaneous read loses to the write
    assign wr_go = (state_q == IDLE) && wr_stb;
    assign rd_go = (state_q == IDLE) && rd_stb && !wr_stb;

    // A CRAM write bumps the address one cycle after its pulse, so any strobe
    // landing in that cycle must already see the incremented value
    assign addr_cur = cram_we_q ? addr_q + ADDR_W'(1) : addr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (wr_go) begin
                    if (mode) begin
                        if (latch_q && vdp_code_t'(data_in[7:6]) == VRD) state_d = VREQ;
                    end else if (code_q != CRAMW) begin
                        state_d = VREQ;
                    end
                end else if (rd_go && !mode) begin
                    state_d = VREQ;
                end
            end
            VREQ:    if (vram_gnt) state_d = vram_we_q ? IDLE : VCAP;
            VCAP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        addr_d       = addr_cur;
        code_d       = code_q;
        first_byte_d = first_byte_q;
        latch_d      = latch_q;
        read_buf_d   = read_buf_q;
        rf_en_d      = 1'b0;
        rf_addr_d    = rf_addr_q;
        rf_data_d    = rf_data_q;
        cram_we_d    = 1'b0;
        cram_addr_d  = cram_addr_q;
        cram_wdata_d = cram_wdata_q;
        status_clr_d = 1'b0;
        vram_we_d    = vram_we_q;
        vram_wdata_d = vram_wdata_q;
        drop_d       = (wr_stb || rd_stb) && ((state_q != IDLE) || (wr_stb && rd_stb));

        if (wr_go && mode) begin
            if (!latch_q) begin
                first_byte_d = data_in;
                addr_d[7:0] = data_in;
                latch_d     = 1'b1;
            end else begin
                code_d = vdp_code_t'(data_in[7:6]);
                addr_d[ADDR_W-1:8] = data_in[ADDR_W-9:0];
                latch_d = 1'b0;
                if (vdp_code_t'(data_in[7:6]) == REGW) begin
                    rf_en_d   = 1'b1;
                    rf_addr_d = data_in[3:0];
                    rf_data_d = first_byte_q;
                end
                if (vdp_code_t'(data_in[7:6]) == VRD) vram_we_d = 1'b0;
            end
        end else if (wr_go) begin
            latch_d    = 1'b0;
            read_buf_d = data_in;
            if (code_q == CRAMW) begin
                cram_we_d    = 1'b1;
                cram_addr_d  = addr_cur[CRAM_W-1:0];
                cram_wdata_d = data_in[5:0];
            end else begin
                vram_we_d    = 1'b1;
                vram_wdata_d = data_in;
            end
        end else if (rd_go && mode) begin
            status_clr_d = 1'b1;
            latch_d      = 1'b0;
        end else if (rd_go) begin
            latch_d   = 1'b0;
            vram_we_d = 1'b0;
        end

        if (state_q == VREQ && vram_gnt && vram_we_q) addr_d = addr_q + ADDR_W'(1);
        if (state_q == VCAP) begin
            read_buf_d = vram_rdata;
            addr_d     = addr_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q       <= '0;
            code_q       <= VRD;
            first_byte_q <= '0;
            latch_q      <= 1'b0;
            read_buf_q   <= '0;
            rf_en_q      <= 1'b0;
            rf_addr_q    <= '0;
            rf_data_q    <= '0;
            cram_we_q    <= 1'b0;
            cram_addr_q  <= '0;
            cram_wdata_q <= '0;
            status_clr_q <= 1'b0;
            vram_we_q    <= 1'b0;
            vram_wdata_q <= '0;
            drop_q       <= 1'b0;
        end else begin
            addr_q       <= addr_d;
            code_q       <= code_d;
            first_byte_q <= first_byte_d;
            latch_q      <= latch_d;
            read_buf_q   <= read_buf_d;
            rf_en_q      <= rf_en_d;
            rf_addr_q    <= rf_addr_d;
            rf_data_q    <= rf_data_d;
            cram_we_q    <= cram_we_d;
            cram_addr_q  <= cram_addr_d;
            cram_wdata_q <= cram_wdata_d;
            status_clr_q <= status_clr_d;
            vram_we_q    <= vram_we_d;
            vram_wdata_q <= vram_wdata_d;
            drop_q       <= drop_d;
        end
    end

    // Request decodes straight from the state flop so reset drops it at once
    always_comb begin
        vram_req = (state_q == VREQ);
        busy     = (state_q != IDLE);
    end

    assign data_out   = mode ? status_in : read_buf_q;
    assign status_clr = status_clr_q;
    assign rf_addr    = rf_addr_q;
    assign rf_data    = rf_data_q;
    assign rf_en      = rf_en_q;
    assign cram_addr  = cram_addr_q;
    assign cram_wdata = cram_wdata_q;
    assign cram_we    = cram_we_q;
    assign vram_addr  = addr_q;
    assign vram_wdata = vram_wdata_q;
    assign vram_we    = vram_we_q;
    assign drop       = drop_q;

endmodule

// File: tb/tb_vdp_cmd_ctrl.sv
// tb/tb_vdp_cmd_ctrl.sv - scoreboard testbench for vdp_cmd_ctrl
module tb_vdp_cmd_ctrl;

    typedef struct {
        logic        we;
        logic [13:0] addr;
        logic [7:0]  wdata;
        int          len;
    } vexp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_stb = 1'b0, rd_stb = 1'b0, mode = 1'b0;
    logic [7:0]  data_in = 8'h00, status_in = 8'h00;
    logic [7:0]  data_out;
    logic        status_clr, rf_en, cram_we, vram_we, vram_req, vram_gnt, busy, drop;
    logic [3:0]  rf_addr;
    logic [7:0]  rf_data, vram_wdata;
    logic [7:0]  vram_rdata = 8'h00;
    logic [4:0]  cram_addr;
    logic [5:0]  cram_wdata;
    logic [13:0] vram_addr;

    logic [7:0]  mem [0:16383];
    int          gnt_delay = 0;
    int          req_cyc = 0;
    int          req_len = 0;
    int          n_checks = 0, n_fail = 0;
    int          n_clr = 0, n_drop = 0;

    vexp_t       vq[$];
    logic [11:0] rfq[$];
    logic [10:0] cq[$];

    always #5 clk = ~clk;

    vdp_cmd_ctrl dut (
        .clk(clk), .rst(rst), .wr_stb(wr_stb), .rd_stb(rd_stb), .mode(mode),
        .data_in(data_in), .data_out(data_out), .status_in(status_in),
        .status_clr(status_clr), .rf_addr(rf_addr), .rf_data(rf_data), .rf_en(rf_en),
        .cram_addr(cram_addr), .cram_wdata(cram_wdata), .cram_we(cram_we),
        .vram_addr(vram_addr), .vram_wdata(vram_wdata), .vram_we(vram_we),
        .vram_req(vram_req), .vram_gnt(vram_gnt), .vram_rdata(vram_rdata),
        .busy(busy), .drop(drop)
    );

    // Grant arrives once the request has waited gnt_delay cycles
    assign vram_gnt = (req_cyc >= gnt_delay);

    always @(posedge clk) begin
        if (vram_req && !vram_gnt) req_cyc <= req_cyc + 1;
        else                       req_cyc <= 0;
        if (vram_req && vram_gnt) begin
            if (vram_we) mem[vram_addr] <= vram_wdata;
            else         vram_rdata <= mem[vram_addr];
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic unexpected(input string nm);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got pulse expected none", nm);
    endtask

    // Monitor: pops expected transactions when the DUT presents them
    always @(negedge clk) begin
        if (rst) begin
            req_len = 0;
        end else begin
            if (vram_req) req_len++;
            if (vram_req && vram_gnt) begin
                if (vq.size() == 0) unexpected("vram_access");
                else begin
                    vexp_t e;
                    e = vq.pop_front();
                    check("vram_we", vram_we, e.we);
                    check("vram_addr", vram_addr, e.addr);
                    if (e.we) check("vram_wdata", vram_wdata, e.wdata);
                    check("vram_req_len", req_len, e.len);
                end
                req_len = 0;
            end
            if (rf_en) begin
                if (rfq.size() == 0) unexpected("rf_en");
                else check("rf_write", {rf_addr, rf_data}, rfq.pop_front());
            end
            if (cram_we) begin
                if (cq.size() == 0) unexpected("cram_we");
                else check("cram_write", {cram_addr, cram_wdata}, cq.pop_front());
            end
            if (status_clr) n_clr++;
            if (drop) n_drop++;
        end
    end

    task automatic strobe(input logic m, input logic w, input logic r, input logic [7:0] d);
        mode = m; wr_stb = w; rd_stb = r; data_in = d;
        @(posedge clk); #1;
        wr_stb = 1'b0; rd_stb = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (busy) begin
            n_checks++; n_fail++;
            $display("FAIL wait_idle: got busy expected idle within 100 cycles");
        end
        @(posedge clk); #1;
    endtask

    task automatic step(input logic m, input logic w, input logic r, input logic [7:0] d);
        strobe(m, w, r, d);
        wait_idle();
    endtask

    task automatic chk_state(input string nm, input logic [13:0] a, input logic [7:0] rb);
        mode = 1'b0;
        #1;
        check({nm, "_addr"}, vram_addr, a);
        check({nm, "_read_buf"}, data_out, rb);
    endtask

    initial begin
        mem[14'h0100] = 8'h12;
        mem[14'h0101] = 8'h34;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req", vram_req, 0);
        check("rst_busy", busy, 0);
        check("rst_rf_en", rf_en, 0);
        check("rst_cram_we", cram_we, 0);
        rst = 1'b0;
        chk_state("reset", 14'h0000, 8'h00);

        // register write
        rfq.push_back({4'h1, 8'h05});
        step(1, 1, 0, 8'h05);
        step(1, 1, 0, 8'h81);
        chk_state("regw", 14'h0105, 8'h00);

        // sequential VRAM writes with grant tied high
        step(1, 1, 0, 8'h00);
        step(1, 1, 0, 8'h40);
        vq.push_back('{1'b1, 14'h0000, 8'hAA, 1});
        step(0, 1, 0, 8'hAA);
        vq.push_back('{1'b1, 14'h0001, 8'hBB, 1});
        step(0, 1, 0, 8'hBB);
        chk_state("vwr", 14'h0002, 8'hBB);

        // address wrap
        step(1, 1, 0, 8'hFF);
        step(1, 1, 0, 8'h7F);
        vq.push_back('{1'b1, 14'h3FFF, 8'h11, 1});
        step(0, 1, 0, 8'h11);
        chk_state("wrap", 14'h0000, 8'h11);

        // prefetch and data read with delayed grant
        gnt_delay = 3;
        step(1, 1, 0, 8'h00);
        vq.push_back('{1'b0, 14'h0100, 8'h00, 4});
        step(1, 1, 0, 8'h01);
        chk_state("prefetch", 14'h0101, 8'h12);
        vq.push_back('{1'b0, 14'h0101, 8'h00, 4});
        mode = 1'b0; rd_stb = 1'b1;
        #3;
        check("data_read", data_out, 8'h12);
        @(posedge clk); #1;
        rd_stb = 1'b0;
        wait_idle();
        chk_state("readahead", 14'h0102, 8'h34);

        // control read breaks latch, then CRAM writes incl. index wrap
        gnt_delay = 0;
        status_in = 8'hA5;
        step(1, 1, 0, 8'h1F);
        mode = 1'b1;
        #1;
        check("status_mux", data_out, 8'hA5);
        step(1, 0, 1, 8'h00);
        step(1, 1, 0, 8'h03);
        step(1, 1, 0, 8'hC0);
        cq.push_back({5'd3, 6'h3F});
        step(0, 1, 0, 8'h3F);
        chk_state("cram", 14'h0004, 8'h3F);
        step(1, 1, 0, 8'h1F);
        step(1, 1, 0, 8'hC0);
        cq.push_back({5'd31, 6'h01});
        step(0, 1, 0, 8'h01);
        cq.push_back({5'd0, 6'h02});
        step(0, 1, 0, 8'h02);
        chk_state("cram_wrap", 14'h0021, 8'h02);

        // simultaneous write and read: write wins, drop pulses
        cq.push_back({5'd1, 6'h05});
        step(0, 1, 1, 8'h05);
        chk_state("wr_rd", 14'h0022, 8'h05);

        // strobe during VREQ is dropped
        gnt_delay = 5;
        step(1, 1, 0, 8'h00);
        step(1, 1, 0, 8'h40);
        vq.push_back('{1'b1, 14'h0000, 8'h77, 6});
        strobe(0, 1, 0, 8'h77);
        strobe(0, 1, 0, 8'h99);
        check("drop_busy", busy, 1);
        check("drop_addr", vram_addr, 14'h0000);
        wait_idle();
        chk_state("drop", 14'h0001, 8'h77);

        // reset in VREQ
        gnt_delay = 20;
        step(1, 1, 0, 8'h55);
        strobe(1, 1, 0, 8'h00);
        @(posedge clk); #2;
        check("pre_rst_req", vram_req, 1);
        rst = 1'b1;
        #1;
        check("mid_rst_req", vram_req, 0);
        check("mid_rst_busy", busy, 0);
        chk_state("mid_rst", 14'h0000, 8'h00);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        gnt_delay = 0;
        rfq.push_back({4'h1, 8'h05});
        step(1, 1, 0, 8'h05);
        step(1, 1, 0, 8'h81);

        repeat (3) @(posedge clk);
        #1;
        check("vram_queue_empty", vq.size(), 0);
        check("rf_queue_empty", rfq.size(), 0);
        check("cram_queue_empty", cq.size(), 0);
        check("status_clr_count", n_clr, 1);
        check("drop_count", n_drop, 2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vdp_cmd_ctrl.md
# vdp_cmd_ctrl

Command sequencer for the VDP's CPU-facing side. It decodes the two-byte control-port protocol and the data-port accesses that arrive from the port decoder, then issues the resulting operations: register-file writes, CRAM writes, and VRAM reads and writes. It owns the 14-bit auto-incrementing access address and the one-byte read-ahead buffer, and it arbitrates its VRAM accesses through a req/gnt handshake with the VRAM port mux. It sits between `vdp_port_decoder` and the RF/CRAM/VRAM blocks.

## Interface
Parameters:
- `ADDR_W`, default 14: VRAM address width.
- `CRAM_W`, default 5: CRAM address width.

Ports:
- `clk`  in  1  VDP system clock. One clock; everything is synchronous to `clk`.
- `rst`  in  1  Asynchronous, active-high reset.
- `wr_stb`  in  1  One-cycle pulse: the CPU wrote a port.
- `rd_stb`  in  1  One-cycle pulse: the CPU read a port.
- `mode`  in  1  Port select, qualifies the strobes: 1 = control port, 0 = data port.
- `data_in`  in  8  CPU write byte, valid with `wr_stb`.
- `data_out`  out  8  Combinational: `status_in` when `mode`=1, else `read_buf`.
- `status_in`  in  8  Status register value from the interrupt logic.
- `status_clr`  out  1  Pulse that clears the status flags after a control-port read.
- `rf_addr`  out  4  Register-file write address.
- `rf_data`  out  8  Register-file write data.
- `rf_en`  out  1  Register-file write pulse.
- `cram_addr`  out  5  CRAM write address.
- `cram_wdata`  out  6  CRAM write data.
- `cram_we`  out  1  CRAM write pulse.
- `vram_addr`  out  14  VRAM access address.
- `vram_wdata`  out  8  VRAM write data.
- `vram_we`  out  1  Access type: 1 = write, 0 = read. Meaningful only while `vram_req` is high.
- `vram_req`  out  1  VRAM access request.
- `vram_gnt`  in  1  VRAM access grant.
- `vram_rdata`  in  8  VRAM read data.
- `busy`  out  1  High whenever the state is not IDLE.
- `drop`  out  1  Pulse: a strobe arrived while `busy` and was ignored.

## Operation
Internal state:
- `addr[13:0]`, `code[1:0]`, `first_byte[7:0]`, `latch` flag, `read_buf[7:0]`.

Codes:
- 0 = VRAM read, 1 = VRAM write, 2 = register write, 3 = CRAM write.

Control-port write (`mode`=1, `wr_stb`):
- With `latch`=0: `first_byte` ← `data_in`; `addr[7:0]` ← `data_in`; `latch` ← 1.
- With `latch`=1: `code` ← `data_in[7:6]`; `addr[13:8]` ← `data_in[5:0]`; `latch` ← 0. Then, by code:
  - Code 2: pulse `rf_en` with `rf_addr` = `data_in[3:0]` and `rf_data` = `first_byte`.
  - Code 0: start a VRAM prefetch (see below).
  - Codes 1 and 3: nothing further.

Control-port read (`mode`=1, `rd_stb`):
- Pulse `status_clr`; `latch` ← 0.

Data-port write (`mode`=0, `wr_stb`):
- `latch` ← 0 and `read_buf` ← `data_in`.
- Code 3: pulse `cram_we` with `cram_addr` = `addr[4:0]` and `cram_wdata` = `data_in[5:0]`, then increment `addr`.
- Any other code: perform a VRAM write of `data_in` at `addr`, then increment `addr`.

Data-port read (`mode`=0, `rd_stb`):
- `data_out` presents the current `read_buf` during the strobe cycle.
- Then `latch` ← 0 and a VRAM prefetch starts.

Prefetch:
- VRAM read at `addr`; `read_buf` ← `vram_rdata`; `addr` increments.

Address arithmetic:
- `addr` increments modulo 2^14, so 0x3FFF wraps to 0x0000.
- The CRAM address is `addr[4:0]`, so it wraps at 31.

FSM states:
- IDLE
- VREQ: `vram_req`=1; addr, wdata and we held stable. Goes to VCAP on `vram_gnt` for a read, or back to IDLE on `vram_gnt` for a write, with `addr`+1.
- VCAP: `read_buf` ← `vram_rdata`; `addr`+1; return to IDLE.

Strobes are accepted only in IDLE. In any other state the strobe is ignored and `drop` pulses.

## Timing
- A strobe in cycle N produces registered outputs in cycle N+1. `rf_en`, `cram_we` and `status_clr` are high for exactly cycle N+1.
- The CRAM write and the register write complete in N+1. The incremented `addr` is visible in N+2.
- VRAM:
  - `vram_req` rises in N+1 and holds until the cycle in which `vram_gnt` is sampled high, inclusive. It drops in the following cycle.
  - Read data is valid on `vram_rdata` the cycle after the grant and is captured in VCAP.
  - If a grant is already high when `vram_req` rises, the access completes in N+1. A read then lands in `read_buf` at the end of N+2.
- `wr_stb` and `rd_stb` in the same cycle: the write wins and `drop` pulses.
- Reset, including reset mid-operation: state IDLE, and all of `addr`, `code`, `first_byte`, `latch`, `read_buf` = 0. All outputs are 0 except `data_out`, which follows its mux. A pending `vram_req` drops immediately.

## Structure
- The `vdp_pkg` package holds:
  - `vdp_code_t` (the 2-bit enum: VRD, VWR, REGW, CRAMW).
  - `cmd_state_t` (IDLE, VREQ, VCAP).
  - `VDP_ADDR_W` = 14, `VDP_CRAM_W` = 5.
- Single module. The address counter is inline because it is too small to justify a sub-module.

## Test plan
- Control writes 0x05 then 0x81 → `rf_en` pulses with `rf_addr`=1 and `rf_data`=0x05; `latch`=0.
- Control writes 0x00, 0x40, then data writes 0xAA and 0xBB with `vram_gnt` tied high → VRAM writes 0xAA at 0x0000 and 0xBB at 0x0001; `addr` ends at 0x0002.
- Control writes 0xFF, 0x7F (addr 0x3FFF, code 1), then data write 0x11 → write at 0x3FFF; `addr` wraps to 0x0000.
- VRAM holds 0x12 at 0x0100 and 0x34 at 0x0101; control writes 0x00 then 0x01; grant delayed 3 cycles → `vram_req` is held 4 cycles; `read_buf`=0x12. A data read returns 0x12, then `read_buf`=0x34 and `addr`=0x0102.
- Control write 0x1F, then a control read (which breaks the latch), then control writes 0x03 and 0xC0, then data write 0x3F → `status_clr` pulses; CRAM index 3 is written with 0x3F.
- `wr_stb` during VREQ → `drop` pulses and the state is unchanged. Assert `rst` in VREQ → `vram_req` drops at once and all registers read 0.
